wt_dcache_ship_pred: RTL and testbench
======================================

Name: wt_dcache_ship_pred

Overview:
- Signature-based re-reference predictor for the write-through L1 dcache (4-way).
- Produces the 2-bit insertion prediction consumed by the SRRIP replacement block when a miss is installed.
- Trains a saturating-counter table (SHCT) indexed by a PC/address signature:
  - a line's first hit trains the counter up;
  - eviction of a never-reused line trains it down.
- Sits beside the replacement block and receives the same miss/fill and hit event streams.

Parameters:
- SIG_WIDTH, 8: signature width; SHCT has 2^SIG_WIDTH entries.
- CNT_WIDTH, 3: SHCT counter width.
- CNT_INIT, 1: SHCT value after reset/flush.
- NUM_SETS, DCACHE_NUM_WORDS: cache sets tracked.
- NUM_WAYS, DCACHE_SET_ASSOC: ways per set; fixed at 4.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low.
- flush_i  in  1  synchronous clear of all state to reset values.
- pred_sig_i  in  SIG_WIDTH  signature of the missing access.
- pred_result_o  out  2  prediction: 0 distant, 2 intermediate, 3 near.
- fill_i  in  1  miss line installed this cycle.
- fill_idx_i  in  DCACHE_CL_IDX_WIDTH  set of the installed line.
- fill_way_i  in  2  victim way being replaced.
- fill_sig_i  in  SIG_WIDTH  signature of the installed line.
- hit_i  in  1  cache hit this cycle.
- hit_idx_i  in  DCACHE_CL_IDX_WIDTH  set of the hit.
- hit_way_i  in  2  way of the hit.

Behaviour:
- State:
  - SHCT: 2^SIG_WIDTH x CNT_WIDTH counters.
  - Per-line metadata [NUM_SETS][NUM_WAYS]: {valid, reused, sig[SIG_WIDTH]}.
  - Two-entry training register: {inc_v, inc_sig, dec_v, dec_sig}.
- Reset (async, rst_ni=0) and flush_i=1 (sync, next edge):
  - all SHCT entries = CNT_INIT;
  - all metadata valid=0, reused=0, sig=0;
  - inc_v=dec_v=0.
  - After reset, pred_result_o=2 for any pred_sig_i (CNT_INIT=1).
  - flush_i overrides all events in the same cycle.
- Prediction, combinational from registered SHCT, zero latency (same cycle as the miss):
  - SHCT[pred_sig_i]==0 -> 0;
  - SHCT[pred_sig_i]==2^CNT_WIDTH-1 -> 3;
  - otherwise -> 2.
  - Value 1 is never produced.
- Fill, when fill_i=1, at the next edge:
  - Old meta at [fill_idx_i][fill_way_i]: if valid=1 and reused=0, then dec_v<=1 and dec_sig<=old sig; else dec_v<=0.
  - New meta <= {valid=1, reused=0, sig=fill_sig_i}.
- Hit, when hit_i=1 and meta[hit_idx_i][hit_way_i] is valid with reused=0:
  - set reused=1;
  - inc_v<=1, inc_sig<=meta sig.
- Hit with reused=1 or valid=0: no training (inc_v<=0).
- Stage 2, applied at the edge after capture:
  - inc_v: SHCT[inc_sig]+1, saturating at 2^CNT_WIDTH-1.
  - dec_v: SHCT[dec_sig]-1, saturating at 0.
  - inc_v and dec_v on the same signature: counter unchanged.
- Latency:
  - counter change visible on pred_result_o 2 cycles after the event edge;
  - metadata change visible 1 cycle after.
  - No bypass of in-flight training into prediction.
- Simultaneous fill and hit:
  - Different line: both processed.
  - Same [idx][way]: fill wins, hit ignored (miss path prioritised).
- Back-to-back hits to one line: only the first increments.
- Reset asserted mid-training: pending inc/dec discarded.

Optional Feature:
- Macro: WT_DCACHE_SHIP_STATS_EN.
- Defined:
  - Adds outputs stat_near_o[31:0], stat_distant_o[31:0], stat_train_o[31:0].
  - Counters increment on fill_i when the prediction is 3 (near), on fill_i when the prediction is 0 (distant), and on each applied inc_v or dec_v respectively.
  - All three saturate at 32'hFFFFFFFF and clear on reset/flush.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, pred_sig_i=8'h00 and 8'hFF -> pred_result_o=2; all SHCT=1.
- Fill idx0 way0 sig 8'h12, then hit idx0 way0 for 6 consecutive cycles -> SHCT[12]=2 (single increment); pred for 12 is 2.
- Per fill idx0 way0 sig 8'h34, hit once; repeat over 6 distinct lines -> SHCT[34]=7 saturates; pred=3; further first-hits keep it at 7.
- Fill idx1 way2 sig 8'h56, no hit, refill same way sig 8'h78 -> SHCT[56] 1->0; pred for 56=0; another unreused eviction keeps it at 0.
- Same cycle: hit to a first-use line sig 8'h9A, and fill evicting an unreused line with sig 8'h9A -> SHCT[9A] unchanged at 1; fill and hit to the same idx/way -> metadata reflects fill, reused=0, no increment.
- Flush after training SHCT[34]=7 -> next cycle pred for 34 is 2, all lines invalid; a hit afterwards produces no training.

Source files
------------

// File: rtl/wt_dcache_ship_pred.sv
// wt_dcache_ship_pred: SHiP-style signature re-reference predictor feeding SRRIP insertion (4-way dcache).
// Optional fill/training statistics outputs are enabled with `define WT_DCACHE_SHIP_STATS_EN.
module wt_dcache_ship_pred #(
  parameter int unsigned SIG_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 3,
  parameter int unsigned CNT_INIT  = 1,
  parameter int unsigned NUM_SETS  = 256,
  parameter int unsigned NUM_WAYS  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [SIG_WIDTH-1:0]        pred_sig_i,
  output logic [1:0]                  pred_result_o,
  input  logic                        fill_i,
  input  logic [$clog2(NUM_SETS)-1:0] fill_idx_i,
  input  logic [1:0]                  fill_way_i,
  input  logic [SIG_WIDTH-1:0]        fill_sig_i,
  input  logic                        hit_i,
  input  logic [$clog2(NUM_SETS)-1:0] hit_idx_i,
  input  logic [1:0]                  hit_way_i
`ifdef WT_DCACHE_SHIP_STATS_EN
  ,
  output logic [31:0]                 stat_near_o,
  output logic [31:0]                 stat_distant_o,
  output logic [31:0]                 stat_train_o
`endif
);
  logic [CNT_WIDTH-1:0] shct_q [2**SIG_WIDTH];
  logic [NUM_WAYS-1:0]  meta_v_q [NUM_SETS];
  logic [NUM_WAYS-1:0]  meta_r_q [NUM_SETS];
  logic [SIG_WIDTH-1:0] meta_sig_q [NUM_SETS][NUM_WAYS];
  logic                 inc_v_q, dec_v_q;
  logic [SIG_WIDTH-1:0] inc_sig_q, dec_sig_q;
  logic [CNT_WIDTH-1:0] pred_cnt, inc_cnt, dec_cnt;
  logic                 hit_train, evict_dead, same_line, cancel;
  always_comb begin
    pred_cnt      = shct_q[pred_sig_i];
    pred_result_o = ~|pred_cnt ? 2'd0 : &pred_cnt ? 2'd3 : 2'd2;
    inc_cnt       = shct_q[inc_sig_q];
    dec_cnt       = shct_q[dec_sig_q];
    same_line     = fill_i && fill_idx_i == hit_idx_i && fill_way_i == hit_way_i;
    hit_train     = hit_i && !same_line && meta_v_q[hit_idx_i][hit_way_i] && !meta_r_q[hit_idx_i][hit_way_i];
    evict_dead    = meta_v_q[fill_idx_i][fill_way_i] && !meta_r_q[fill_idx_i][fill_way_i];
    cancel        = inc_v_q && dec_v_q && inc_sig_q == dec_sig_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2**SIG_WIDTH; i++) shct_q[i] <= CNT_WIDTH'(CNT_INIT);
      for (int s = 0; s < NUM_SETS; s++) begin
        meta_v_q[s] <= '0;
        meta_r_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) meta_sig_q[s][w] <= '0;
      end
      inc_v_q   <= 1'b0;
      dec_v_q   <= 1'b0;
      inc_sig_q <= '0;
      dec_sig_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < 2**SIG_WIDTH; i++) shct_q[i] <= CNT_WIDTH'(CNT_INIT);
      for (int s = 0; s < NUM_SETS; s++) begin
        meta_v_q[s] <= '0;
        meta_r_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) meta_sig_q[s][w] <= '0;
      end
      inc_v_q   <= 1'b0;
      dec_v_q   <= 1'b0;
      inc_sig_q <= '0;
      dec_sig_q <= '0;
    end else begin
      // an increment and decrement on one signature cancel out
      if (inc_v_q && !cancel) shct_q[inc_sig_q] <= &inc_cnt ? inc_cnt : inc_cnt + CNT_WIDTH'(1);
      if (dec_v_q && !cancel) shct_q[dec_sig_q] <= ~|dec_cnt ? dec_cnt : dec_cnt - CNT_WIDTH'(1);
      inc_v_q   <= hit_train;
      inc_sig_q <= meta_sig_q[hit_idx_i][hit_way_i];
      dec_v_q   <= fill_i && evict_dead;
      dec_sig_q <= meta_sig_q[fill_idx_i][fill_way_i];
      if (hit_train) meta_r_q[hit_idx_i][hit_way_i] <= 1'b1;
      if (fill_i) begin
        meta_v_q[fill_idx_i][fill_way_i]   <= 1'b1;
        meta_r_q[fill_idx_i][fill_way_i]   <= 1'b0;
        meta_sig_q[fill_idx_i][fill_way_i] <= fill_sig_i;
      end
    end
  end
`ifdef WT_DCACHE_SHIP_STATS_EN
  logic [32:0] train_sum;
  always_comb train_sum = 33'(stat_train_o) + 33'(inc_v_q) + 33'(dec_v_q);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_near_o    <= '0;
      stat_distant_o <= '0;
      stat_train_o   <= '0;
    end else if (flush_i) begin
      stat_near_o    <= '0;
      stat_distant_o <= '0;
      stat_train_o   <= '0;
    end else begin
      if (fill_i && pred_result_o == 2'd3 && !(&stat_near_o)) stat_near_o <= stat_near_o + 32'd1;
      if (fill_i && pred_result_o == 2'd0 && !(&stat_distant_o)) stat_distant_o <= stat_distant_o + 32'd1;
      stat_train_o <= train_sum[32] ? '1 : train_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_wt_dcache_ship_pred.sv
// tb_wt_dcache_ship_pred: directed scoreboard bench; driver queues expected predictions, negedge monitor checks them.
module tb_wt_dcache_ship_pred;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       flush_i = 1'b0;
  logic [7:0] pred_sig_i = '0;
  logic [1:0] pred_result_o;
  logic       fill_i = 1'b0;
  logic [7:0] fill_idx_i = '0;
  logic [1:0] fill_way_i = '0;
  logic [7:0] fill_sig_i = '0;
  logic       hit_i = 1'b0;
  logic [7:0] hit_idx_i = '0;
  logic [1:0] hit_way_i = '0;
  logic       chk_v = 1'b0;
  int         n_vec = 0;
  int         n_fail = 0;
  typedef struct {string name; logic [1:0] exp;} exp_t;
  exp_t sb[$];

  wt_dcache_ship_pred dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .pred_sig_i(pred_sig_i), .pred_result_o(pred_result_o),
    .fill_i(fill_i), .fill_idx_i(fill_idx_i), .fill_way_i(fill_way_i), .fill_sig_i(fill_sig_i),
    .hit_i(hit_i), .hit_idx_i(hit_idx_i), .hit_way_i(hit_way_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (chk_v) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL monitor: check strobe with empty scoreboard");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (pred_result_o !== e.exp) begin
          n_fail++;
          $display("FAIL %s: pred_result_o=%0d expected %0d (sig %h)", e.name, pred_result_o, e.exp, pred_sig_i);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ev(input logic f, input logic [7:0] fi, input logic [1:0] fw, input logic [7:0] fs,
                    input logic h, input logic [7:0] hi, input logic [1:0] hw);
    fill_i = f; fill_idx_i = fi; fill_way_i = fw; fill_sig_i = fs;
    hit_i = h; hit_idx_i = hi; hit_way_i = hw;
    tick();
    fill_i = 1'b0;
    hit_i = 1'b0;
  endtask

  task automatic fill(input logic [7:0] fi, input logic [1:0] fw, input logic [7:0] fs);
    ev(1'b1, fi, fw, fs, 1'b0, '0, '0);
  endtask

  task automatic hit(input logic [7:0] hi, input logic [1:0] hw);
    ev(1'b0, '0, '0, '0, 1'b1, hi, hw);
  endtask

  task automatic idle();
    ev(1'b0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic chk(input logic [7:0] sig, input logic [1:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.exp = exp;
    sb.push_back(e);
    pred_sig_i = sig;
    chk_v = 1'b1;
    tick();
    chk_v = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();
    chk(8'h00, 2'd2, "rst_sig00");
    chk(8'hFF, 2'd2, "rst_sigff");
    chk(8'h12, 2'd2, "rst_sig12");
    // one first hit among six consecutive hits: 1 -> 2, then two dead evictions reach 0
    fill(8'd0, 2'd0, 8'h12);
    repeat (6) hit(8'd0, 2'd0);
    idle();
    chk(8'h12, 2'd2, "hit12_pred");
    fill(8'd5, 2'd0, 8'h12);
    fill(8'd5, 2'd0, 8'h12);
    idle();
    fill(8'd5, 2'd0, 8'h12);
    idle();
    chk(8'h12, 2'd0, "hit12_single_inc");
    // six first hits on distinct lines saturate 34 at 7
    for (int i = 0; i < 6; i++) begin
      fill(8'(8 + i), 2'(i % 4), 8'h34);
      hit(8'(8 + i), 2'(i % 4));
      if (i == 4) begin
        idle();
        chk(8'h34, 2'd2, "sig34_cnt6");
      end
    end
    idle();
    chk(8'h34, 2'd3, "sig34_near");
    fill(8'd20, 2'd0, 8'h34);
    hit(8'd20, 2'd0);
    idle();
    idle();
    chk(8'h34, 2'd3, "sig34_sat7");
    // unreused eviction trains down, saturating at 0, with two-cycle visibility
    fill(8'd1, 2'd2, 8'h56);
    idle();
    fill(8'd1, 2'd2, 8'h78);
    chk(8'h56, 2'd2, "sig56_no_bypass");
    chk(8'h56, 2'd0, "sig56_dec");
    fill(8'd1, 2'd3, 8'h56);
    idle();
    fill(8'd1, 2'd3, 8'h78);
    idle();
    chk(8'h56, 2'd0, "sig56_sat0");
    // same-cycle inc and dec on 9A cancel; one later dead eviction shows it stayed at 1
    fill(8'd2, 2'd0, 8'h9A);
    fill(8'd2, 2'd1, 8'h9A);
    idle();
    ev(1'b1, 8'd2, 2'd1, 8'hBB, 1'b1, 8'd2, 2'd0);
    idle();
    chk(8'h9A, 2'd2, "sig9a_cancel");
    fill(8'd3, 2'd0, 8'h9A);
    fill(8'd3, 2'd0, 8'hCC);
    idle();
    chk(8'h9A, 2'd0, "sig9a_was1");
    // fill and hit to one line: fill wins, hit does not train the old signature
    fill(8'd4, 2'd0, 8'hDE);
    idle();
    ev(1'b1, 8'd4, 2'd0, 8'hEE, 1'b1, 8'd4, 2'd0);
    idle();
    chk(8'hDE, 2'd0, "same_line_fill_wins");
    fill(8'd4, 2'd0, 8'h01);
    idle();
    chk(8'hEE, 2'd0, "same_line_meta_unreused");
    // flush restores counters and invalidates every line
    flush_i = 1'b1;
    ev(1'b1, 8'd9, 2'd0, 8'h34, 1'b1, 8'd1, 2'd2);
    flush_i = 1'b0;
    chk(8'h34, 2'd2, "flush_sig34");
    chk(8'h56, 2'd2, "flush_sig56");
    fill(8'd1, 2'd2, 8'h11);
    hit(8'd1, 2'd3);
    idle();
    chk(8'h78, 2'd2, "flush_meta_invalid");
    fill(8'd6, 2'd0, 8'h78);
    fill(8'd6, 2'd0, 8'h00);
    idle();
    chk(8'h78, 2'd0, "flush_hit_no_train");
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
endmodule
